// File: rtl/adder_pkg.sv
// Shared operation codes for the adder/subtractor datapath blocks.
package adder_pkg;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
endpackage

// File: rtl/csel_pipe_adder_if.sv
// Operand/result handshake bundle for csel_pipe_adder.
interface csel_pipe_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/csel_slice.sv
// Combinational BLK-bit carry-select slice: two ripple sums (ci=0/1) and a
// final select, also reporting the carry into the slice MSB.
module csel_slice #(
  parameter int BLK = 4
) (
  input  logic [BLK-1:0] a,
  input  logic [BLK-1:0] b,
  input  logic           ci,
  output logic [BLK-1:0] s,
  output logic           co,
  output logic           cmsb
);
  logic [BLK:0] r0;
  logic [BLK:0] r1;
  logic         cm0;
  logic         cm1;

  always_comb begin
    r0   = {1'b0, a} + {1'b0, b};
    r1   = {1'b0, a} + {1'b0, b} + {{BLK{1'b0}}, 1'b1};
    // the MSB sum bit is a^b^carry_in, so the carry in is recovered by XOR
    cm0  = a[BLK-1] ^ b[BLK-1] ^ r0[BLK-1];
    cm1  = a[BLK-1] ^ b[BLK-1] ^ r1[BLK-1];
    s    = ci ? r1[BLK-1:0] : r0[BLK-1:0];
    co   = ci ? r1[BLK]     : r0[BLK];
    cmsb = ci ? cm1         : cm0;
  end
endmodule

// File: rtl/csel_pipe_adder.sv
// Pipelined carry-select adder/subtractor: one BLK-bit slice resolved per
// stage, operands skewed down the pipe, single global stall (adv).
module csel_pipe_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int BLK   = 4
) (
  input  logic            clk,
  input  logic            rst,
  csel_pipe_adder_if.slave bus
);
  localparam int STAGES = WIDTH / BLK;

  logic             adv;
  logic [WIDTH-1:0] bx_in;

  assign bx_in        = (bus.sub == OP_SUB) ? ~bus.b : bus.b;
  assign adv          = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = adv && !rst;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int DONE = (k + 1) * BLK;
    localparam int REM  = WIDTH - DONE;

    logic [BLK-1:0]  sa;
    logic [BLK-1:0]  sb;
    logic [BLK-1:0]  ss;
    logic            ci;
    logic            co;
    logic            cm;
    logic            vld_in;
    logic [DONE-1:0] sum_nx;
    logic            vld_p;
    logic [DONE-1:0] sum_p;
    logic            c_p;
    logic            cm_p;

    if (k == 0) begin : g_in
      assign sa     = bus.a[BLK-1:0];
      assign sb     = bx_in[BLK-1:0];
      assign ci     = bus.cin;
      assign vld_in = bus.in_valid;
      assign sum_nx = ss;
    end else begin : g_in
      assign sa     = g_stage[k-1].g_skew.a_p[BLK-1:0];
      assign sb     = g_stage[k-1].g_skew.bx_p[BLK-1:0];
      assign ci     = g_stage[k-1].c_p;
      assign vld_in = g_stage[k-1].vld_p;
      assign sum_nx = {ss, g_stage[k-1].sum_p};
    end

    csel_slice #(.BLK(BLK)) u_slice (
      .a   (sa),
      .b   (sb),
      .ci  (ci),
      .s   (ss),
      .co  (co),
      .cmsb(cm)
    );

    // ---- stage k register boundary ----
    always_ff @(posedge clk) begin
      if (rst) begin
        vld_p <= 1'b0;
        sum_p <= '0;
        c_p   <= 1'b0;
        cm_p  <= 1'b0;
      end else if (adv) begin
        vld_p <= vld_in;
        sum_p <= sum_nx;
        c_p   <= co;
        cm_p  <= cm;
      end
    end

    if (k < STAGES - 1) begin : g_unused
      // the MSB carry-in only feeds ovf, which is taken from the final stage
      logic unused_cm;
      assign unused_cm = cm_p;
    end

    if (REM > 0) begin : g_skew
      logic [REM-1:0] a_p;
      logic [REM-1:0] bx_p;
      if (k == 0) begin : g_src
        always_ff @(posedge clk) begin
          if (adv) begin
            a_p  <= bus.a[WIDTH-1:BLK];
            bx_p <= bx_in[WIDTH-1:BLK];
          end
        end
      end else begin : g_src
        always_ff @(posedge clk) begin
          if (adv) begin
            a_p  <= g_stage[k-1].g_skew.a_p[REM+BLK-1:BLK];
            bx_p <= g_stage[k-1].g_skew.bx_p[REM+BLK-1:BLK];
          end
        end
      end
    end
  end

  assign bus.out_valid = g_stage[STAGES-1].vld_p;
  assign bus.sum       = g_stage[STAGES-1].sum_p;
  assign bus.cout      = g_stage[STAGES-1].c_p;
  assign bus.ovf       = g_stage[STAGES-1].cm_p ^ g_stage[STAGES-1].c_p;
endmodule

// File: tb/tb_csel_pipe_adder.sv
// Directed and random bench for csel_pipe_adder (WIDTH=16, BLK=4).
module tb_csel_pipe_adder;
  localparam int WIDTH  = 16;
  localparam int BLK    = 4;
  localparam int STAGES = WIDTH / BLK;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  csel_pipe_adder_if #(.WIDTH(WIDTH)) bus ();

  csel_pipe_adder #(.WIDTH(WIDTH), .BLK(BLK)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // returns {ovf, cout, sum}
  function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic cin, input logic sub);
    logic [15:0] bx;
    logic [16:0] full;
    logic [15:0] low;
    bx   = sub ? ~b : b;
    full = {1'b0, a} + {1'b0, bx} + 17'(cin);
    low  = {1'b0, a[14:0]} + {1'b0, bx[14:0]} + 16'(cin);
    return {low[15] ^ full[16], full[16], full[15:0]};
  endfunction

  task automatic init_inputs();
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b1;
  endtask

  task automatic single_beat(input logic [15:0] ta, input logic [15:0] tb_, input logic tc,
                             input logic ts, output logic [15:0] rs, output logic rco,
                             output logic rov, output int lat);
    @(negedge clk);
    bus.a = ta; bus.b = tb_; bus.cin = tc; bus.sub = ts;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    rs = bus.sum; rco = bus.cout; rov = bus.ovf;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); else passed++;
    checks++; if (bus.sum !== 16'h0000) $display("FAIL reset_sum: got %h want 0000", bus.sum); else passed++;
    checks++; if (bus.cout !== 1'b0) $display("FAIL reset_cout: got %b want 0", bus.cout); else passed++;
    checks++; if (bus.ovf !== 1'b0) $display("FAIL reset_ovf: got %b want 0", bus.ovf); else passed++;
    checks++; if (bus.in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); else passed++;
    rst = 1'b0;
    #1;
    checks++; if (bus.in_ready !== 1'b1) $display("FAIL post_reset_in_ready: got %b want 1", bus.in_ready); else passed++;
  endtask

  task automatic test_directed();
    logic [15:0] va  [9] = '{16'hFFFF, 16'h7FFF, 16'h8000, 16'h0005, 16'h1234,
                             16'h0000, 16'h8000, 16'h0F0F, 16'h0007};
    logic [15:0] vb  [9] = '{16'h0001, 16'h0001, 16'h0001, 16'h0007, 16'h4321,
                             16'h0000, 16'h8000, 16'h00F1, 16'h0005};
    logic        vc  [9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic        vs  [9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [15:0] es  [9] = '{16'h0000, 16'h8000, 16'h7FFF, 16'hFFFE, 16'h5556,
                             16'h0000, 16'h0000, 16'h1000, 16'h0001};
    logic        eco [9] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic        eov [9] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [15:0] rs;
    logic        rco;
    logic        rov;
    int          lat;
    for (int i = 0; i < 9; i++) begin
      single_beat(va[i], vb[i], vc[i], vs[i], rs, rco, rov, lat);
      checks++; if (lat !== STAGES) $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, STAGES); else passed++;
      checks++; if (rs !== es[i]) $display("FAIL dir%0d_sum: got %h want %h", i, rs, es[i]); else passed++;
      checks++; if (rco !== eco[i]) $display("FAIL dir%0d_cout: got %b want %b", i, rco, eco[i]); else passed++;
      checks++; if (rov !== eov[i]) $display("FAIL dir%0d_ovf: got %b want %b", i, rov, eov[i]); else passed++;
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] va [8] = '{16'h0001, 16'hFFFF, 16'h8000, 16'h1234, 16'hABCD, 16'h0F0F, 16'h7FFF, 16'h0000};
    logic [15:0] vb [8] = '{16'h0002, 16'hFFFF, 16'h0001, 16'h4321, 16'h1111, 16'hF0F0, 16'h8000, 16'h0001};
    logic        vc [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic        vs [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [17:0] q [$];
    logic [17:0] exp;
    logic [18:0] held;
    bit          stall_prev = 0;
    int          sent = 0;
    int          got = 0;
    int          cyc = 0;
    while (got < 8 && cyc < 60) begin
      @(negedge clk);
      bus.out_ready = !(cyc >= 5 && cyc <= 7);
      if (sent < 8) begin
        bus.a = va[sent]; bus.b = vb[sent]; bus.cin = vc[sent]; bus.sub = vs[sent];
        bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      if (bus.out_valid && !bus.out_ready) begin
        checks++; if (bus.in_ready !== 1'b0) $display("FAIL b2b_stall_in_ready c%0d: got %b want 0", cyc, bus.in_ready); else passed++;
        if (stall_prev) begin
          checks++;
          if ({bus.out_valid, bus.ovf, bus.cout, bus.sum} !== held)
            $display("FAIL b2b_stall_hold c%0d: got %h want %h", cyc, {bus.out_valid, bus.ovf, bus.cout, bus.sum}, held);
          else passed++;
        end
        held = {bus.out_valid, bus.ovf, bus.cout, bus.sum};
        stall_prev = 1;
      end else begin
        stall_prev = 0;
      end
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (q.size() == 0) begin
          $display("FAIL b2b_extra_result c%0d: got %h want none", cyc, {bus.ovf, bus.cout, bus.sum});
        end else begin
          exp = q.pop_front();
          if ({bus.ovf, bus.cout, bus.sum} !== exp)
            $display("FAIL b2b_result%0d: got %h want %h", got, {bus.ovf, bus.cout, bus.sum}, exp);
          else passed++;
        end
        got++;
      end
      if (bus.in_valid && bus.in_ready) begin
        q.push_back(model(bus.a, bus.b, bus.cin, bus.sub));
        sent++;
      end
      cyc++;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    checks++; if (got !== 8 || sent !== 8 || q.size() != 0) $display("FAIL b2b_count: got %0d results want 8", got); else passed++;
  endtask

  task automatic test_reset_mid();
    int          nvalid = 0;
    int          first_lat = 0;
    logic [15:0] rs = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.a = 16'h0100 * 16'(i + 1); bus.b = 16'h0001; bus.cin = 1'b0; bus.sub = 1'b0;
      bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (bus.in_ready !== 1'b0) $display("FAIL midrst_in_ready: got %b want 0", bus.in_ready); else passed++;
    rst = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL midrst_out_valid: got %b want 0", bus.out_valid); else passed++;
    bus.a = 16'h1111; bus.b = 16'h2222; bus.cin = 1'b0; bus.sub = 1'b0;
    bus.in_valid = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      #1;
      if (bus.out_valid) begin
        nvalid++;
        if (nvalid == 1) begin
          first_lat = c;
          rs = bus.sum;
        end
      end
    end
    checks++; if (nvalid !== 1) $display("FAIL midrst_result_count: got %0d want 1", nvalid); else passed++;
    checks++; if (first_lat !== STAGES) $display("FAIL midrst_latency: got %0d want %0d", first_lat, STAGES); else passed++;
    checks++; if (rs !== 16'h3333) $display("FAIL midrst_sum: got %h want 3333", rs); else passed++;
  endtask

  task automatic test_random();
    localparam int N = 10000;
    logic [17:0] q [$];
    logic [17:0] exp;
    int          sent = 0;
    int          got = 0;
    int          cyc = 0;
    while (got < N && cyc < 60000) begin
      @(negedge clk);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      if (sent < N) begin
        bus.in_valid = ($urandom_range(0, 3) != 0);
        bus.a   = 16'($urandom);
        bus.b   = 16'($urandom);
        bus.cin = 1'($urandom_range(0, 1));
        bus.sub = 1'($urandom_range(0, 1));
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (q.size() == 0) begin
          $display("FAIL rnd_extra_result: got %h want none", {bus.ovf, bus.cout, bus.sum});
        end else begin
          exp = q.pop_front();
          if ({bus.ovf, bus.cout, bus.sum} !== exp)
            $display("FAIL rnd_result%0d: got %h want %h", got, {bus.ovf, bus.cout, bus.sum}, exp);
          else passed++;
        end
        got++;
      end
      if (bus.in_valid && bus.in_ready) begin
        q.push_back(model(bus.a, bus.b, bus.cin, bus.sub));
        sent++;
      end
      cyc++;
    end
    bus.in_valid = 1'b0;
    checks++; if (got !== N) $display("FAIL rnd_count: got %0d want %0d", got, N); else passed++;
  endtask

  initial begin
    init_inputs();
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/csel_pipe_adder.md
# csel_pipe_adder

Pipelined, parametrised carry-select adder/subtractor with valid/ready flow control. Operands are split into `BLK`-bit slices. Each pipeline stage resolves one slice with a carry-select pair (two ripple sums, carry-in 0 and 1), then selects between them using the registered carry from the previous stage. It is the datapath adder for multi-cycle arithmetic units that need wide operands at high clock rate, and it replaces single-cycle fixed-width carry-select adders.

## Interface
- `WIDTH`, 16: operand and sum width in bits; must be a multiple of `BLK`.
- `BLK`, 4: slice width per pipeline stage; `STAGES = WIDTH/BLK` (≥1).
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  operand beat present.
- `in_ready`  out  1  block can accept a beat this cycle.
- `a`, `b`  in  WIDTH  operands.
- `cin`  in  1  carry-in (chaining; set to 1 for plain subtract).
- `sub`  in  1  0: a+b+cin; 1: a+~b+cin.
- `out_valid`  out  1  result beat present.
- `out_ready`  in  1  consumer accepts the result.
- `sum`  out  WIDTH  result, modulo 2^WIDTH.
- `cout`  out  1  carry out of bit WIDTH-1 (for subtract: 1 = no borrow).
- `ovf`  out  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation
- Effective operand `bx = sub ? ~b : b`, computed at the input before stage 0.
- Stage k (0..STAGES-1) computes slice k, bits [k*BLK+BLK-1 : k*BLK]. It forms `s0/c0 = a_k+bx_k+0` and `s1/c1 = a_k+bx_k+1`, then selects on the incoming carry. Stage 0 uses `cin`; stage k>0 uses stage k-1's registered carry.
- Each stage register holds:
  - valid bit,
  - completed low sum bits,
  - outgoing carry,
  - carry into that slice's MSB (needed for `ovf` at the last stage),
  - the not-yet-consumed upper slices of `a` and `bx` (operand skew).
- Global advance: `adv = !out_valid || out_ready`. When `adv` is high, every stage loads from its predecessor, and stage 0 loads the input beat (valid = `in_valid`). When `adv` is low, all stages hold.
- `in_ready = adv && !rst`. A beat transfers when `in_valid && in_ready`.
- Outputs are driven directly from the last stage register. `ovf` uses the registered MSB carry-in and `cout`.
- Bubbles propagate as invalid stages. No reordering, no combining.
- Arithmetic is pure modulo 2^WIDTH. Any `cin` value is legal in either mode.

## Timing
- Reset (while `rst`=1 at an edge): all stage valid bits cleared; `out_valid`=0, `sum`=0, `cout`=0, `ovf`=0. `in_ready`=0 while `rst` is high.
- Reset mid-operation discards every in-flight beat. No result for those beats ever appears.
- Latency: a beat accepted at edge t presents `out_valid`=1 after edge t+STAGES-1, i.e. STAGES cycles of latency. This assumes no stall.
- Throughput: one beat per cycle while `out_ready`=1.
- Stall: with `out_valid`=1 and `out_ready`=0, the following hold stable until the handshake completes:
  - `sum`, `cout`, `ovf`, `out_valid`;
  - all internal stages;
  - `in_ready` = 0.
- Simultaneous output pop and input push in the same cycle is legal at full rate. A full pipeline accepts a new beat in the same cycle it delivers one.
- Critical path per stage: one BLK-bit ripple plus one 2:1 mux.

## Structure
- Shared package `adder_pkg`: `OP_ADD=1'b0`, `OP_SUB=1'b1`.
- Sub-module `csel_slice`: combinational BLK-bit carry-select slice.
  - Inputs: `a`, `b`, `ci`.
  - Outputs: `s`, `co`, `cmsb` (carry into the slice MSB).
  - Instantiated STAGES times via generate.
- Top level contains only the stage registers, skew shifting and handshake logic.

## Test plan
All scenarios use WIDTH=16, BLK=4, so latency is 4 cycles.
- ADD 0xFFFF+0x0001, cin=0, out_ready=1 → 4 cycles later: sum=0x0000, cout=1, ovf=0.
- ADD 0x7FFF+0x0001, cin=0 → sum=0x8000, cout=0, ovf=1. SUB 0x8000−0x0001 with cin=1 → sum=0x7FFF, cout=1, ovf=1.
- SUB 0x0005−0x0007, cin=1 → sum=0xFFFE, cout=0, ovf=0.
- 8 back-to-back beats with out_ready low on cycles 5–7:
  - output stays frozen and in_ready=0 during the stall;
  - results emerge in order with no loss or duplication;
  - check against a reference model.
- Assert rst for 1 cycle while 3 beats are in flight → out_valid=0 next cycle. Only beats issued after reset appear, at the correct latency.
- Random 10k beats with random in_valid/out_ready, both modes, random cin → every result matches `(a + (sub?~b:b) + cin)` to 17 bits, and ovf matches the signed-overflow model.
